// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C bus master.
//
// Contents:
//   cmd_e     host command codes carried on cmd_i (codes 5..7 are unused)
//   state_e   controller states; RESTART is split into a low-SCL and a
//             high-SCL half so that every phase can have its own counter run
//   DATA_BITS bits per byte transfer (8 data bits plus the ACK slot)
//   LAST_BIT  index of the final bit, in the bit counter's width
package i2c_pkg;

   typedef enum logic [2:0] {
      CMD_START   = 3'd0,
      CMD_WR      = 3'd1,
      CMD_RD      = 3'd2,
      CMD_STOP    = 3'd3,
      CMD_RESTART = 3'd4
   } cmd_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START1,
      ST_START2,
      ST_HOLD,
      ST_DATA1,
      ST_DATA2,
      ST_DATA3,
      ST_DATA4,
      ST_DATA_END,
      ST_RESTART1,
      ST_RESTART2,
      ST_STOP1,
      ST_STOP2
   } state_e;

   localparam int         DATA_BITS = 9;
   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

endpackage

// File: rtl/i2c_master.sv
// Command-driven I2C bus master with open-drain SCL/SDA.
//
// The host strobes one command at a time (START, WR, RD, STOP, RESTART)
// while ready_o is high. Bus timing is built from a quarter-bit divisor:
// a quarter phase lasts dvsr_i clocks and a half phase 2*dvsr_i clocks.
// The phase counter is 16 bits wide, so the longest half phase it can time
// is 65536 clocks (dvsr_i up to 32768).
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous reset, active low
//   din_i        byte to write; bit 0 is the master ACK bit for a read
//   dvsr_i       quarter-bit length in clocks (>= 2), held stable while busy
//   cmd_i        command code (see i2c_pkg::cmd_e)
//   wr_i2c_i     one-cycle command strobe
//   scl_io       open-drain clock line (drives 0 or Z)
//   sda_io       open-drain data line (drives 0 or Z)
//   ready_o      high while a new command can be accepted
//   done_tick_o  one-cycle pulse when a WR/RD byte completes
//   ack_o        ninth bit seen on SDA during the last WR/RD
//   dout_o       byte seen on SDA during the last WR/RD
module i2c_master
   import i2c_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  din_i,
   input  logic [15:0] dvsr_i,
   input  logic [2:0]  cmd_i,
   input  logic        wr_i2c_i,
   inout  wire         scl_io,
   inout  wire         sda_io,
   output logic        ready_o,
   output logic        done_tick_o,
   output logic        ack_o,
   output logic [7:0]  dout_o
);

   state_e      r_state;
   logic [15:0] r_cnt;
   logic [8:0]  r_tx;
   logic [8:0]  r_rx;
   logic [3:0]  r_bitCnt;
   logic        r_scl;
   logic        r_sda;
   logic        r_ready;
   logic        r_done;
   logic        r_ack;
   logic [7:0]  r_dout;

   logic        w_qEnd;
   logic        w_hEnd;
   logic [16:0] w_hLast;
   logic        w_sdaIn;
   logic        w_accept;
   logic [8:0]  w_load;

   // Open-drain pins: a registered 1 releases the line to the pull-up,
   // a 0 pulls it low. SDA is read back from the pin so the sampled value
   // is whatever the bus actually carries.
   assign scl_io  = r_scl ? 1'bz : 1'b0;
   assign sda_io  = r_sda ? 1'bz : 1'b0;
   assign w_sdaIn = sda_io;

   // Phase terminal counts. The half phase is compared in 17 bits so that
   // doubling the divisor cannot wrap.
   assign w_qEnd   = (r_cnt == dvsr_i - 16'd1);
   assign w_hLast  = {dvsr_i, 1'b0} - 17'd1;
   assign w_hEnd   = ({1'b0, r_cnt} == w_hLast);
   assign w_accept = r_ready & wr_i2c_i;

   // A write shifts out the byte followed by a released ninth bit so the
   // slave can ACK; a read shifts out all ones (bus released) followed by
   // the master's own ACK/NACK bit.
   assign w_load = (cmd_i == CMD_WR) ? {din_i, 1'b1} : {8'hFF, din_i[0]};

   // Main controller. Every transition clears the phase counter and sets
   // the pin and status registers for the state being entered, so the pins
   // always match the current state without any output decoding.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_tx     <= '0;
         r_rx     <= '0;
         r_bitCnt <= '0;
         r_scl    <= 1'b1;
         r_sda    <= 1'b1;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_ack    <= 1'b0;
         r_dout   <= '0;
      end else begin
         r_done <= 1'b0;
         r_cnt  <= r_cnt + 16'd1;
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_accept && cmd_i == CMD_START) begin
                  r_state <= ST_START1;
                  r_sda   <= 1'b0;
                  r_scl   <= 1'b1;
                  r_ready <= 1'b0;
               end
            end
            ST_START1: begin
               if (w_hEnd) begin
                  r_state <= ST_START2;
                  r_cnt   <= '0;
                  r_scl   <= 1'b0;
               end
            end
            ST_START2: begin
               if (w_qEnd) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
                  r_ready <= 1'b1;
               end
            end
            ST_HOLD: begin
               r_cnt <= '0;
               if (w_accept) begin
                  if (cmd_i == CMD_WR || cmd_i == CMD_RD) begin
                     r_state  <= ST_DATA1;
                     r_tx     <= w_load;
                     r_sda    <= w_load[8];
                     r_bitCnt <= '0;
                     r_ready  <= 1'b0;
                  end else if (cmd_i == CMD_STOP) begin
                     r_state <= ST_STOP1;
                     r_sda   <= 1'b0;
                     r_scl   <= 1'b1;
                     r_ready <= 1'b0;
                  end else if (cmd_i == CMD_RESTART || cmd_i == CMD_START) begin
                     r_state <= ST_RESTART1;
                     r_sda   <= 1'b1;
                     r_ready <= 1'b0;
                  end
               end
            end
            ST_DATA1: begin
               if (w_qEnd) begin
                  r_state <= ST_DATA2;
                  r_cnt   <= '0;
                  r_scl   <= 1'b1;
               end
            end
            ST_DATA2: begin
               // Sample in the middle of the SCL-high time.
               if (w_qEnd) begin
                  r_state <= ST_DATA3;
                  r_cnt   <= '0;
                  r_rx    <= {r_rx[7:0], w_sdaIn};
               end
            end
            ST_DATA3: begin
               if (w_qEnd) begin
                  r_state <= ST_DATA4;
                  r_cnt   <= '0;
                  r_scl   <= 1'b0;
               end
            end
            ST_DATA4: begin
               if (w_qEnd) begin
                  r_cnt <= '0;
                  r_tx  <= {r_tx[7:0], 1'b0};
                  if (r_bitCnt == LAST_BIT) begin
                     r_state <= ST_DATA_END;
                  end else begin
                     r_state  <= ST_DATA1;
                     r_bitCnt <= r_bitCnt + 4'd1;
                     r_sda    <= r_tx[7];
                  end
               end
            end
            ST_DATA_END: begin
               if (w_qEnd) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
                  r_dout  <= r_rx[8:1];
                  r_ack   <= r_rx[0];
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
               end
            end
            ST_RESTART1: begin
               if (w_qEnd) begin
                  r_state <= ST_RESTART2;
                  r_cnt   <= '0;
                  r_scl   <= 1'b1;
               end
            end
            ST_RESTART2: begin
               if (w_hEnd) begin
                  r_state <= ST_START1;
                  r_cnt   <= '0;
                  r_sda   <= 1'b0;
               end
            end
            ST_STOP1: begin
               if (w_hEnd) begin
                  r_state <= ST_STOP2;
                  r_cnt   <= '0;
                  r_sda   <= 1'b1;
               end
            end
            ST_STOP2: begin
               if (w_hEnd) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_scl   <= 1'b1;
               r_sda   <= 1'b1;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready_o     = r_ready;
   assign done_tick_o = r_done;
   assign ack_o       = r_ack;
   assign dout_o      = r_dout;

endmodule

// File: tb/tb_i2c_master.sv
`timescale 1ns/1ps
module tb_i2c_master;
   import i2c_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [7:0]  din;
   logic [15:0] dvsr;
   logic [2:0]  cmd;
   logic        wr;
   wire         scl;
   wire         sda;
   logic        readyO;
   logic        doneO;
   logic        ackO;
   logic [7:0]  doutO;

   logic        slvDrive;
   logic        slvPresent;
   logic [7:0]  slvByte;
   logic        compareOn;

   int checks = 0;
   int errors = 0;

   pullup(scl);
   pullup(sda);
   assign sda = slvDrive ? 1'b0 : 1'bz;

   i2c_master dut (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .din_i      (din),
      .dvsr_i     (dvsr),
      .cmd_i      (cmd),
      .wr_i2c_i   (wr),
      .scl_io     (scl),
      .sda_io     (sda),
      .ready_o    (readyO),
      .done_tick_o(doneO),
      .ack_o      (ackO),
      .dout_o     (doutO)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bus-level model: every accepted command expands into a queue of
   // per-clock expected pin levels (SCL, master SDA, slave pull-down).
   // When the queue is empty the bus is parked: idle (both high) or held
   // between transfers (SCL low, SDA at the last master level).
   typedef struct packed {
      logic scl;
      logic sda;
      logic slv;
      logic last;
   } ent_t;

   ent_t        q[$];
   logic        inBus;
   logic        lastSda;
   logic        prevReady;
   logic        pendDone;
   logic        pendAck;
   logic [7:0]  pendDout;
   logic        expScl;
   logic        expSda;
   logic        expReady;
   logic        expDone;
   logic        expAck;
   logic [7:0]  expDout;

   task automatic pushN(input int n, input logic s, input logic d, input logic sl, input logic lastSeg);
      ent_t e;
      for (int i = 0; i < n; i++) begin
         e.scl  = s;
         e.sda  = d;
         e.slv  = sl;
         e.last = lastSeg && (i == n - 1);
         q.push_back(e);
      end
   endtask

   task automatic modelAccept(input logic [2:0] c, input logic [7:0] d);
      int         qn;
      int         hn;
      logic [8:0] m;
      logic [8:0] sv;
      logic [8:0] b;
      qn = int'(dvsr);
      hn = 2 * qn;
      if (!inBus) begin
         if (c == CMD_START) begin
            pushN(hn, 1'b1, 1'b0, 1'b0, 1'b0);
            pushN(qn, 1'b0, 1'b0, 1'b0, 1'b0);
            inBus   = 1'b1;
            lastSda = 1'b0;
         end
      end else if (c == CMD_WR || c == CMD_RD) begin
         if (c == CMD_WR) begin
            m  = {d, 1'b1};
            sv = {8'hFF, ~slvPresent};
         end else begin
            m  = {8'hFF, d[0]};
            sv = slvPresent ? {slvByte, 1'b1} : 9'h1FF;
         end
         b = m & sv;
         for (int i = 8; i >= 0; i--) begin
            pushN(qn,     1'b0, m[i], ~sv[i], 1'b0);
            pushN(2 * qn, 1'b1, m[i], ~sv[i], 1'b0);
            pushN(qn,     1'b0, m[i], ~sv[i], 1'b0);
         end
         pushN(qn, 1'b0, m[0], 1'b0, 1'b1);
         pendDout = b[8:1];
         pendAck  = b[0];
         lastSda  = m[0];
      end else if (c == CMD_STOP) begin
         pushN(hn, 1'b1, 1'b0, 1'b0, 1'b0);
         pushN(hn, 1'b1, 1'b1, 1'b0, 1'b0);
         inBus   = 1'b0;
         lastSda = 1'b1;
      end else if (c == CMD_START || c == CMD_RESTART) begin
         pushN(qn, 1'b0, 1'b1, 1'b0, 1'b0);
         pushN(hn, 1'b1, 1'b1, 1'b0, 1'b0);
         pushN(hn, 1'b1, 1'b0, 1'b0, 1'b0);
         pushN(qn, 1'b0, 1'b0, 1'b0, 1'b0);
         lastSda = 1'b0;
      end
   endtask

   // Model advance: one step per rising clock edge, reset asynchronously.
   initial begin
      ent_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            inBus     = 1'b0;
            lastSda   = 1'b1;
            prevReady = 1'b1;
            pendDone  = 1'b0;
            pendAck   = 1'b0;
            pendDout  = 8'h00;
            expScl    = 1'b1;
            expSda    = 1'b1;
            expReady  = 1'b1;
            expDone   = 1'b0;
            expAck    = 1'b0;
            expDout   = 8'h00;
            slvDrive  = 1'b0;
         end else begin
            expDone = 1'b0;
            if (prevReady && wr) modelAccept(cmd, din);
            if (q.size() != 0) begin
               e        = q.pop_front();
               expScl   = e.scl;
               expSda   = e.sda & ~e.slv;
               slvDrive = e.slv;
               expReady = 1'b0;
               if (e.last) pendDone = 1'b1;
            end else begin
               expReady = 1'b1;
               slvDrive = 1'b0;
               expScl   = inBus ? 1'b0 : 1'b1;
               expSda   = inBus ? lastSda : 1'b1;
               if (pendDone) begin
                  expDone  = 1'b1;
                  pendDone = 1'b0;
                  expDout  = pendDout;
                  expAck   = pendAck;
               end
            end
            prevReady = expReady;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (compareOn && rst_n) begin
            checkOutput("cyc_scl",   {7'b0, scl},    {7'b0, expScl});
            checkOutput("cyc_sda",   {7'b0, sda},    {7'b0, expSda});
            checkOutput("cyc_ready", {7'b0, readyO}, {7'b0, expReady});
            checkOutput("cyc_done",  {7'b0, doneO},  {7'b0, expDone});
            checkOutput("cyc_ack",   {7'b0, ackO},   {7'b0, expAck});
            checkOutput("cyc_dout",  doutO,          expDout);
         end
      end
   end

   // One command strobe; returns at the falling edge just after acceptance.
   task automatic applyStimulus(input logic [2:0] c, input logic [7:0] d);
      @(negedge clk);
      cmd = c;
      din = d;
      wr  = 1'b1;
      @(negedge clk);
      wr  = 1'b0;
   endtask

   // Watches the bus until ready returns (plus two cycles), collecting the
   // SDA level at each SCL rise and counting START/STOP conditions.
   task automatic watchBus(input int budget, output logic [15:0] bits, output int nBits,
                           output int gap, output int doneCnt, output int starts, output int stops);
      logic pScl;
      logic pSda;
      int   firstRise;
      int   cyc;
      bits = '0; nBits = 0; gap = -1; doneCnt = 0; starts = 0; stops = 0;
      firstRise = -1; cyc = -1;
      pScl = scl; pSda = sda;
      for (int i = 0; i < budget; i++) begin
         if (doneO) doneCnt++;
         if (!pScl && scl) begin
            bits = {bits[14:0], sda};
            nBits++;
            if (firstRise < 0) firstRise = i;
            else if (gap < 0) gap = i - firstRise;
         end
         if (pScl && scl && pSda && !sda) starts++;
         if (pScl && scl && !pSda && sda) stops++;
         if (readyO && cyc < 0) cyc = i;
         if (cyc >= 0 && i >= cyc + 2) break;
         pScl = scl;
         pSda = sda;
         @(negedge clk);
      end
      checkOutput("byteTimeout", {7'b0, (cyc < 0)}, 8'd0);
   endtask

   logic [15:0] bits;
   int          nBits;
   int          gap;
   int          doneCnt;
   int          starts;
   int          stops;
   int          sclFall;
   int          rdyAt;
   int          activity;

   // Directed sequence with hand-computed expectations (dvsr = 4: Q = 4,
   // H = 8, one bit = 16 clocks).
   initial begin
      rst_n = 1'b1; wr = 1'b0; cmd = 3'd0; din = 8'h00; dvsr = 16'd4;
      slvPresent = 1'b0; slvByte = 8'h00; compareOn = 1'b0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready", {7'b0, readyO}, 8'd1);
      checkOutput("rst_dout",  doutO,          8'h00);
      checkOutput("rst_ack",   {7'b0, ackO},   8'd0);
      checkOutput("rst_scl",   {7'b0, scl},    8'd1);
      checkOutput("rst_sda",   {7'b0, sda},    8'd1);
      rst_n = 1'b1;
      compareOn = 1'b1;

      // WR while idle must be ignored.
      applyStimulus(CMD_WR, 8'h55);
      activity = 0;
      for (int i = 0; i < 20; i++) begin
         if (!scl || !sda || !readyO) activity++;
         @(negedge clk);
      end
      checkOutput("idle_wr_ignored", 8'(activity), 8'd0);

      // START: SDA falls with SCL high, SCL falls 8 clocks later, ready at 12.
      applyStimulus(CMD_START, 8'h00);
      checkOutput("start_ready_drop", {7'b0, readyO}, 8'd0);
      checkOutput("start_scl_high",   {7'b0, scl},    8'd1);
      checkOutput("start_sda_low",    {7'b0, sda},    8'd0);
      sclFall = -1; rdyAt = -1;
      for (int i = 0; i < 100; i++) begin
         if (sclFall < 0 && !scl) sclFall = i;
         if (readyO) begin
            rdyAt = i;
            break;
         end
         @(negedge clk);
      end
      checkOutput("start_scl_fall", 8'(sclFall), 8'd8);
      checkOutput("start_ready_at", 8'(rdyAt),   8'd12);

      // WR 0xA5 with an ACKing slave.
      slvPresent = 1'b1;
      applyStimulus(CMD_WR, 8'hA5);
      watchBus(400, bits, nBits, gap, doneCnt, starts, stops);
      checkOutput("wr_nbits", 8'(nBits),   8'd9);
      checkOutput("wr_bits_hi", bits[8:1], 8'hA5);
      checkOutput("wr_bit9",  {7'b0, bits[0]}, 8'd0);
      checkOutput("wr_gap",   8'(gap),     8'd16);
      checkOutput("wr_done",  8'(doneCnt), 8'd1);
      checkOutput("wr_dout",  doutO,       8'hA5);
      checkOutput("wr_ack",   {7'b0, ackO}, 8'd0);

      // WR 0x3A with no slave; a STOP strobe mid-byte must be ignored.
      slvPresent = 1'b0;
      applyStimulus(CMD_WR, 8'h3A);
      repeat (20) @(negedge clk);
      applyStimulus(CMD_STOP, 8'h00);
      watchBus(400, bits, nBits, gap, doneCnt, starts, stops);
      checkOutput("nack_done",  8'(doneCnt), 8'd1);
      checkOutput("nack_stops", 8'(stops),   8'd0);
      checkOutput("nack_dout",  doutO,       8'h3A);
      checkOutput("nack_ack",   {7'b0, ackO}, 8'd1);

      // RD with NACK, slave returns 0x3C.
      slvPresent = 1'b1;
      slvByte    = 8'h3C;
      applyStimulus(CMD_RD, 8'h01);
      watchBus(400, bits, nBits, gap, doneCnt, starts, stops);
      checkOutput("rd1_bits", bits[7:0], 8'h79);
      checkOutput("rd1_dout", doutO,     8'h3C);
      checkOutput("rd1_ack",  {7'b0, ackO}, 8'd1);

      // RD with master ACK: bit 9 pulled low by the master.
      applyStimulus(CMD_RD, 8'h00);
      watchBus(400, bits, nBits, gap, doneCnt, starts, stops);
      checkOutput("rd0_bit9", {7'b0, bits[0]}, 8'd0);
      checkOutput("rd0_dout", doutO,           8'h3C);
      checkOutput("rd0_ack",  {7'b0, ackO},    8'd0);

      // Repeated START with no STOP in between.
      slvPresent = 1'b0;
      applyStimulus(CMD_RESTART, 8'h00);
      watchBus(400, bits, nBits, gap, doneCnt, starts, stops);
      checkOutput("rs_starts", 8'(starts), 8'd1);
      checkOutput("rs_stops",  8'(stops),  8'd0);

      // STOP: SDA rises with SCL high, then idle.
      applyStimulus(CMD_STOP, 8'h00);
      watchBus(400, bits, nBits, gap, doneCnt, starts, stops);
      checkOutput("stop_stops",  8'(stops),  8'd1);
      checkOutput("stop_starts", 8'(starts), 8'd0);
      checkOutput("stop_ready",  {7'b0, readyO}, 8'd1);
      checkOutput("stop_scl",    {7'b0, scl},    8'd1);
      checkOutput("stop_sda",    {7'b0, sda},    8'd1);

      // Reset in the middle of a byte releases both lines at once.
      applyStimulus(CMD_START, 8'h00);
      watchBus(100, bits, nBits, gap, doneCnt, starts, stops);
      applyStimulus(CMD_WR, 8'h00);
      repeat (10) @(negedge clk);
      checkOutput("mid_sda_low", {7'b0, sda}, 8'd0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_scl",   {7'b0, scl},    8'd1);
      checkOutput("mid_rst_sda",   {7'b0, sda},    8'd1);
      checkOutput("mid_rst_ready", {7'b0, readyO}, 8'd1);
      checkOutput("mid_rst_dout",  doutO,          8'h00);
      checkOutput("mid_rst_ack",   {7'b0, ackO},   8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Byte-level, command-driven I2C bus master with open-drain SCL/SDA.
- Host issues one command per `wr_i2c_i` pulse: START, WRITE, READ, STOP or RESTART.
- Block generates bus timing from a programmable quarter-bit divisor and reports ready, completion, slave ACK and read data.
- Sits between a host register interface and the external I2C pins.

Parameters:
- none: all timing comes from `dvsr_i`.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `din_i`  in  8  write byte for WR; bit 0 is the master ACK bit for RD (0 = ACK, 1 = NACK).
- `dvsr_i`  in  16  quarter-bit-period length in clocks; legal values ≥ 2.
- `cmd_i`  in  3  command: 0 START, 1 WR, 2 RD, 3 STOP, 4 RESTART; 5–7 ignored.
- `wr_i2c_i`  in  1  one-cycle command strobe.
- `scl_io`  inout  1  open-drain clock: drives 0 or Z.
- `sda_io`  inout  1  open-drain data: drives 0 or Z.
- `ready_o`  out  1  block accepts a command this cycle.
- `done_tick_o`  out  1  one-cycle pulse at end of a WR/RD byte.
- `ack_o`  out  1  9th bit sampled on SDA during the last WR/RD.
- `dout_o`  out  8  byte sampled during the last RD (also updated on WR).

Behaviour:
- Pins: each line has a registered output bit `o`. Pin = Z when `o`=1, 0 when `o`=0. Bus pull-ups are external. Inputs are read from the pins.
- Timing: `Q` = `dvsr_i` clocks; half period `H` = 2·`dvsr_i` clocks.
  - A 16-bit counter clears on every state entry.
  - A phase ends when the counter reaches its length−1.
  - `dvsr_i` is sampled continuously, so host must keep it stable while busy.
- Reset, asynchronous and active-low, forces:
  - state = IDLE;
  - SCL and SDA released;
  - `ready_o`=1, `done_tick_o`=0, `ack_o`=0, `dout_o`=0;
  - shift registers and bit counter = 0.
- Reset mid-transfer releases both lines immediately.
- `ready_o`=1 only in IDLE and HOLD. A strobe when `ready_o`=0 is ignored.
- IDLE: SCL=1, SDA=1.
  - START → START1.
  - Any other command is ignored.
- START1: SDA=0, SCL=1 for `H`, then → START2.
- START2: SDA=0, SCL=0 for `Q`, then → HOLD.
- HOLD: SCL=0, SDA unchanged. On accepted commands:
  - WR or RD: load tx shift register, bit count = 0 → DATA1.
  - STOP → STOP1.
  - RESTART or START → RESTART.
- Load values:
  - WR: `{din_i[7:0], 1}` (releases SDA for the slave ACK).
  - RD: `{8'hFF, din_i[0]}`.
- Per-bit phases, 9 bits, MSB first:
  - DATA1: SCL=0, SDA=tx[8], `Q`.
  - DATA2: SCL=1, `Q`; at its last cycle sample SDA into the rx shift register LSB.
  - DATA3: SCL=1, `Q`.
  - DATA4: SCL=0, `Q`; then shift tx left.
  - If bit count = 8 → DATA_END, else bit count+1 → DATA1.
- DATA_END: SCL=0, `Q`. At exit:
  - `dout_o` = rx[8:1], `ack_o` = rx[0];
  - `done_tick_o`=1 for exactly one cycle;
  - → HOLD.
- RESTART: SDA=1, SCL=0 for `Q`, then SCL=1 for `H`, then → START1.
- STOP1: SDA=0, SCL=1 for `H`.
- STOP2: SDA=1, SCL=1 for `H`, then → IDLE.
- SDA only changes while SCL=0, except during START, STOP and RESTART conditions.
- No clock stretching and no arbitration: SCL is not monitored.

Decomposition:
- Package `i2c_pkg`:
  - command enum (`CMD_START`=0, `CMD_WR`=1, `CMD_RD`=2, `CMD_STOP`=3, `CMD_RESTART`=4);
  - state enum;
  - `DATA_BITS`=9.
- No sub-module needed. Open-drain buffers are continuous assigns in the top module.

Test Plan:
- Reset while `rst_i`=0:
  - `ready_o`=1, `dout_o`=0, `ack_o`=0, both pins Z (read 1 with pull-ups).
  - Assert reset mid-byte → lines release in the same cycle.
- `dvsr_i`=4, START:
  - `ready_o` drops.
  - SDA falls while SCL high; SCL falls 8 clocks later; `ready_o` returns after 12 clocks total.
- WR `din_i`=8'hA5, slave model ACKs:
  - SDA bits 1,0,1,0,0,1,0,1 appear on SCL rising edges, each bit 16 clocks.
  - `done_tick_o` pulses once and `ack_o`=0.
  - Repeat with no slave → `ack_o`=1.
- RD `din_i[0]`=1, slave drives 8'h3C:
  - `dout_o`=8'h3C.
  - 9th bit released → `ack_o`=1.
  - With `din_i[0]`=0, master pulls SDA low in bit 9.
- RESTART then STOP:
  - Repeated START occurs with no STOP between.
  - STOP: SDA rises while SCL high, then block returns to IDLE with `ready_o`=1.
- Ignored strobes:
  - WR issued in IDLE → no bus activity.
  - Strobe while busy → no effect on the current byte.
